tetron_rot_shaper: RTL and testbench
====================================

Name: tetron_rot_shaper

Overview:
- Parametrised successor to the per-piece shapers: a single block covering all seven tetrominoes.
- Owns the falling piece's rotation state and produces the four block offsets relative to the pivot block (blk1).
- Rotation is not applied blindly. A candidate shape goes to the external collision checker through a request/response handshake, with optional horizontal wall-kick retries.
- Sits between the input/game controller and the playfield collision logic.

Parameters:
- OFS_W, 5: width of each signed (two's complement) offset.
- KICK_EN, 1: 1 = after a failed check, retry with kick +1, then -1; 0 = no retries.
- CHK_TIMEOUT, 15: cycles to wait for a checker response before treating the attempt as fail; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- active  in  1  piece in play; 0 forces outputs to zero and the FSM to IDLE
- load  in  1  1-cycle pulse: latch piece_type, rotation := 0, kick := 0
- piece_type  in  3  0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L, 7 invalid
- rot_cw  in  1  rotate-clockwise request pulse
- rot_ccw  in  1  rotate-counter-clockwise request pulse
- chk_ok  in  1  checker: candidate fits
- chk_fail  in  1  checker: candidate collides
- cur_v  out  4*OFS_W  committed v offsets; blk1 in [OFS_W-1:0] … blk4 in the top field
- cur_h  out  4*OFS_W  committed h offsets, same packing
- cand_v  out  4*OFS_W  candidate v offsets
- cand_h  out  4*OFS_W  candidate h offsets; kick already added to each
- cand_kick  out  OFS_W  kick of the current candidate
- cand_valid  out  1  candidate presented to the checker
- rotation  out  2  committed rotation, 0..3
- kick_h  out  OFS_W  kick of the last commit; the controller adds it to the anchor
- busy  out  1  FSM not in IDLE
- rot_done  out  1  1-cycle pulse: rotation committed
- rot_rejected  out  1  1-cycle pulse: rotation abandoned

Behaviour:
- Reset (rst high at a clk edge):
  - all outputs 0, FSM IDLE, piece latch 7, rotation 0, attempt counter 0, timeout counter 0.
- Coordinates: v positive = down, h positive = right. Rotation-0 shapes as (v,h), blk1..blk4:
  - I: (0,0)(0,-1)(0,1)(0,2)
  - O: (0,0)(0,1)(1,0)(1,1)
  - T: (0,0)(0,-1)(0,1)(-1,0)
  - S: (0,0)(0,-1)(-1,0)(-1,1)
  - Z: (0,0)(0,1)(-1,0)(-1,-1)
  - J: (0,0)(0,1)(0,-1)(-1,-1)
  - L: (0,0)(0,1)(0,-1)(-1,1)
  - invalid (7): all zero
- Rotation arithmetic:
  - one CW step maps (v,h) -> (h,-v), applied rotation times;
  - O ignores rotation, and its offsets are constant;
  - all arithmetic is OFS_W-bit two's complement; cand_h = shape_h + kick, wrapping modulo 2^OFS_W.
- cur_v/cur_h are registered and update the cycle after load or after a commit.
- FSM IDLE:
  - rot_cw XOR rot_ccw with a valid piece -> target = rotation ±1 mod 4 (3+1 -> 0, 0-1 -> 3), attempt 0, kick 0 -> PRESENT.
  - rot_cw and rot_ccw together -> ignored, no pulse.
  - piece 7 with a request -> rot_rejected pulse, stay IDLE.
- FSM PRESENT:
  - candidate registers load; cand_valid rises on the next edge -> WAIT.
  - Request at edge N gives cand_valid=1 at N+1.
- FSM WAIT:
  - cand_* and cand_valid are held stable; the timeout counter increments each cycle.
  - chk_ok -> COMMIT.
  - chk_fail, or the counter reaching CHK_TIMEOUT -> RETRY.
  - chk_ok and chk_fail together count as fail.
- FSM RETRY:
  - cand_valid drops for this cycle.
  - KICK_EN=1 and attempt<2 -> attempt++, kick = +1 then -1, counter cleared -> PRESENT.
  - Otherwise -> rot_rejected pulse, committed state unchanged -> IDLE.
- FSM COMMIT:
  - rotation := target, kick_h := kick, cur_* := candidate values;
  - rot_done pulses 1 cycle; cand_valid drops -> IDLE.
  - Request at N with immediate ok gives rot_done at N+3.
- rot_cw/rot_ccw outside IDLE are dropped; no queuing.
- load in any state:
  - aborts the rotation in progress (no pulse), cand_valid := 0, state IDLE;
  - new piece at rotation 0, kick_h 0.
  - load and a rotate in the same cycle: load wins, the rotate is dropped.
- active=0 at any edge: same as reset except the piece latch is kept. The block resumes only on load.
- Reset mid-handshake: cand_valid is low on the next cycle; any later checker response is ignored.

Test Plan:
- rst; load J; rot_cw; chk_ok in the first WAIT cycle -> cand blk4=(-1,1) at N+1; rot_done at N+3; rotation=1; cur_h blk4=1 (0x01), cur_v blk4=-1 (0x1F).
- T at rotation 0; rot_ccw; fail, fail, ok -> candidates carry kicks 0, +1, -1; final kick_h=0x1F, rotation=3, one rot_done, no rot_rejected.
- KICK_EN=0; I piece; rot_cw; no checker response -> cand_valid held 15 cycles, then rot_rejected; rotation=0; cur_* unchanged.
- L at rotation 0; four rot_cw, each acked -> rotation 1,2,3,0 (wrap); rotation-0 offsets restored exactly; O piece cur_* constant throughout.
- rot_cw and rot_ccw together in IDLE -> busy stays 0, no pulses. Piece 7 with rot_cw -> rot_rejected, offsets zero.
- load issued in WAIT -> cand_valid=0 next cycle, no pulse, rotation=0. A late chk_ok changes nothing. Dropping active forces all outputs to 0.

Source files
------------

// File: rtl/tetron_rot_shaper.sv
// Rotation state and block-offset generator for all seven tetrominoes.
// Each rotation goes to an external collision checker first, with optional horizontal wall-kick retries.
module tetron_rot_shaper #(
    parameter int OFS_W       = 5,
    parameter int KICK_EN     = 1,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active,
    input  logic                 load,
    input  logic [2:0]           piece_type,
    input  logic                 rot_cw,
    input  logic                 rot_ccw,
    input  logic                 chk_ok,
    input  logic                 chk_fail,
    output logic [4*OFS_W-1:0]   cur_v,
    output logic [4*OFS_W-1:0]   cur_h,
    output logic [4*OFS_W-1:0]   cand_v,
    output logic [4*OFS_W-1:0]   cand_h,
    output logic [OFS_W-1:0]     cand_kick,
    output logic                 cand_valid,
    output logic [1:0]           rotation,
    output logic [OFS_W-1:0]     kick_h,
    output logic                 busy,
    output logic                 rot_done,
    output logic                 rot_rejected
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT,
        S_RETRY,
        S_COMMIT
    } state_t;

    localparam logic [OFS_W-1:0] Z0 = '0;
    localparam logic [OFS_W-1:0] P1 = OFS_W'(1);
    localparam logic [OFS_W-1:0] P2 = OFS_W'(2);
    localparam logic [OFS_W-1:0] M1 = '1;

    // Packed as {h offsets, v offsets}; O is rotation invariant.
    function automatic logic [8*OFS_W-1:0] shapeOf(input logic [2:0] p, input logic [1:0] r);
        logic [OFS_W-1:0]   bv [4];
        logic [OFS_W-1:0]   bh [4];
        logic [4*OFS_W-1:0] ov;
        logic [4*OFS_W-1:0] oh;
        logic [1:0]         rr;
        ov = '0;
        oh = '0;
        rr = (p == 3'd1) ? 2'd0 : r;
        case (p)
            3'd0:    begin bv = '{Z0, Z0, Z0, Z0}; bh = '{Z0, M1, P1, P2}; end
            3'd1:    begin bv = '{Z0, Z0, P1, P1}; bh = '{Z0, P1, Z0, P1}; end
            3'd2:    begin bv = '{Z0, Z0, Z0, M1}; bh = '{Z0, M1, P1, Z0}; end
            3'd3:    begin bv = '{Z0, Z0, M1, M1}; bh = '{Z0, M1, Z0, P1}; end
            3'd4:    begin bv = '{Z0, Z0, M1, M1}; bh = '{Z0, P1, Z0, M1}; end
            3'd5:    begin bv = '{Z0, Z0, Z0, M1}; bh = '{Z0, P1, M1, M1}; end
            3'd6:    begin bv = '{Z0, Z0, Z0, M1}; bh = '{Z0, P1, M1, P1}; end
            default: begin bv = '{Z0, Z0, Z0, Z0}; bh = '{Z0, Z0, Z0, Z0}; end
        endcase
        for (int i = 0; i < 4; i++) begin
            case (rr)
                2'd0: begin ov[i*OFS_W +: OFS_W] = bv[i];  oh[i*OFS_W +: OFS_W] = bh[i];  end
                2'd1: begin ov[i*OFS_W +: OFS_W] = bh[i];  oh[i*OFS_W +: OFS_W] = -bv[i]; end
                2'd2: begin ov[i*OFS_W +: OFS_W] = -bv[i]; oh[i*OFS_W +: OFS_W] = -bh[i]; end
                2'd3: begin ov[i*OFS_W +: OFS_W] = -bh[i]; oh[i*OFS_W +: OFS_W] = bv[i];  end
            endcase
        end
        return {oh, ov};
    endfunction

    state_t               state_q;
    logic [2:0]           piece_q;
    logic [1:0]           rotation_q;
    logic [1:0]           target_q;
    logic [1:0]           attempt_q;
    logic [7:0]           tmo_q;
    logic [OFS_W-1:0]     kick_q;
    logic [OFS_W-1:0]     kickH_q;
    logic [OFS_W-1:0]     candKick_q;
    logic [4*OFS_W-1:0]   curV_q;
    logic [4*OFS_W-1:0]   curH_q;
    logic [4*OFS_W-1:0]   candV_q;
    logic [4*OFS_W-1:0]   candH_q;
    logic                 candValid_q;
    logic                 rotDone_q;
    logic                 rotRej_q;
    logic                 halted_q;

    logic [8*OFS_W-1:0]   candShape;
    logic [8*OFS_W-1:0]   loadShape;
    logic [4*OFS_W-1:0]   candV_d;
    logic [4*OFS_W-1:0]   candH_d;

    assign candShape = shapeOf(piece_q, target_q);
    assign loadShape = shapeOf(piece_type, 2'd0);

    always_comb begin
        candV_d = candShape[4*OFS_W-1:0];
        candH_d = '0;
        for (int i = 0; i < 4; i++) begin
            candH_d[i*OFS_W +: OFS_W] = candShape[4*OFS_W + i*OFS_W +: OFS_W] + kick_q;
        end
    end

    // Dropping active acts like reset but keeps the piece and stays halted until the next load.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            state_q     <= S_IDLE;
            if (rst) begin
                piece_q <= 3'd7;
            end
            halted_q    <= !rst;
            rotation_q  <= '0;
            target_q    <= '0;
            attempt_q   <= '0;
            tmo_q       <= '0;
            kick_q      <= '0;
            kickH_q     <= '0;
            candKick_q  <= '0;
            curV_q      <= '0;
            curH_q      <= '0;
            candV_q     <= '0;
            candH_q     <= '0;
            candValid_q <= 1'b0;
            rotDone_q   <= 1'b0;
            rotRej_q    <= 1'b0;
        end else if (load) begin
            state_q     <= S_IDLE;
            piece_q     <= piece_type;
            halted_q    <= 1'b0;
            rotation_q  <= '0;
            attempt_q   <= '0;
            tmo_q       <= '0;
            kick_q      <= '0;
            kickH_q     <= '0;
            curV_q      <= loadShape[4*OFS_W-1:0];
            curH_q      <= loadShape[8*OFS_W-1:4*OFS_W];
            candValid_q <= 1'b0;
            rotDone_q   <= 1'b0;
            rotRej_q    <= 1'b0;
        end else begin
            rotDone_q <= 1'b0;
            rotRej_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!halted_q && (rot_cw ^ rot_ccw)) begin
                        if (piece_q == 3'd7) begin
                            rotRej_q <= 1'b1;
                        end else begin
                            target_q  <= rot_cw ? rotation_q + 2'd1 : rotation_q - 2'd1;
                            attempt_q <= '0;
                            kick_q    <= '0;
                            tmo_q     <= '0;
                            state_q   <= S_PRESENT;
                        end
                    end
                end
                S_PRESENT: begin
                    candV_q     <= candV_d;
                    candH_q     <= candH_d;
                    candKick_q  <= kick_q;
                    candValid_q <= 1'b1;
                    tmo_q       <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (chk_fail) begin
                        candValid_q <= 1'b0;
                        state_q     <= S_RETRY;
                    end else if (chk_ok) begin
                        state_q <= S_COMMIT;
                    end else if (tmo_q == 8'(CHK_TIMEOUT - 1)) begin
                        candValid_q <= 1'b0;
                        state_q     <= S_RETRY;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_RETRY: begin
                    if ((KICK_EN != 0) && (attempt_q < 2'd2)) begin
                        attempt_q <= attempt_q + 2'd1;
                        kick_q    <= (attempt_q == 2'd0) ? P1 : M1;
                        tmo_q     <= '0;
                        state_q   <= S_PRESENT;
                    end else begin
                        rotRej_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    rotation_q  <= target_q;
                    kickH_q     <= candKick_q;
                    curV_q      <= candV_q;
                    curH_q      <= candH_q;
                    rotDone_q   <= 1'b1;
                    candValid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    candValid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cur_v        = curV_q;
    assign cur_h        = curH_q;
    assign cand_v       = candV_q;
    assign cand_h       = candH_q;
    assign cand_kick    = candKick_q;
    assign cand_valid   = candValid_q;
    assign rotation     = rotation_q;
    assign kick_h       = kickH_q;
    assign busy         = (state_q != S_IDLE);
    assign rot_done     = rotDone_q;
    assign rot_rejected = rotRej_q;

endmodule

// File: tb/tb_tetron_rot_shaper.sv
// Bench for tetron_rot_shaper: a kicking and a non-kicking instance share stimulus and are
// compared every cycle against a coordinate-arithmetic reference model.
module tb_tetron_rot_shaper;

    localparam int W   = 5;
    localparam int TMO = 15;

    localparam int PH_IDLE    = 0;
    localparam int PH_PRESENT = 1;
    localparam int PH_WAIT    = 2;
    localparam int PH_RETRY   = 3;
    localparam int PH_COMMIT  = 4;

    typedef struct packed {
        int             ph;
        int             piece;
        int             rot;
        int             target;
        int             att;
        int             kick;
        int             waitCnt;
        bit             halted;
        bit             candValid;
        bit             done;
        bit             rej;
        logic [W-1:0]   kickH;
        logic [W-1:0]   candKick;
        logic [4*W-1:0] curV;
        logic [4*W-1:0] curH;
        logic [4*W-1:0] candV;
        logic [4*W-1:0] candH;
    } model_t;

    logic clk = 1'b0;
    logic rst, active, load, rotCw, rotCcw, chkOk, chkFail;
    logic [2:0] pieceType;

    logic [4*W-1:0] dCurV, dCurH, dCandV, dCandH, nCurV, nCurH, nCandV, nCandH;
    logic [W-1:0]   dCandKick, dKickH, nCandKick, nKickH;
    logic [1:0]     dRot, nRot;
    logic           dCandValid, dBusy, dRotDone, dRotRej;
    logic           nCandValid, nBusy, nRotDone, nRotRej;

    int nCompared   = 0;
    int nMismatched = 0;
    int dDoneCnt    = 0;
    int dRejCnt     = 0;
    model_t mDef, mNk;

    always #5 clk = ~clk;

    tetron_rot_shaper #(.OFS_W(W), .KICK_EN(1), .CHK_TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst), .active(active), .load(load), .piece_type(pieceType),
        .rot_cw(rotCw), .rot_ccw(rotCcw), .chk_ok(chkOk), .chk_fail(chkFail),
        .cur_v(dCurV), .cur_h(dCurH), .cand_v(dCandV), .cand_h(dCandH),
        .cand_kick(dCandKick), .cand_valid(dCandValid), .rotation(dRot), .kick_h(dKickH),
        .busy(dBusy), .rot_done(dRotDone), .rot_rejected(dRotRej)
    );

    tetron_rot_shaper #(.OFS_W(W), .KICK_EN(0), .CHK_TIMEOUT(TMO)) u_nokick (
        .clk(clk), .rst(rst), .active(active), .load(load), .piece_type(pieceType),
        .rot_cw(rotCw), .rot_ccw(rotCcw), .chk_ok(chkOk), .chk_fail(chkFail),
        .cur_v(nCurV), .cur_h(nCurH), .cand_v(nCandV), .cand_h(nCandH),
        .cand_kick(nCandKick), .cand_valid(nCandValid), .rotation(nRot), .kick_h(nKickH),
        .busy(nBusy), .rot_done(nRotDone), .rot_rejected(nRotRej)
    );

    // Offsets from integer coordinates: rotate clockwise 'rot' times, add kick to h, truncate.
    function automatic logic [8*W-1:0] refShape(int piece, int rot, int kick);
        int v[4];
        int h[4];
        int t;
        logic [4*W-1:0] pv;
        logic [4*W-1:0] ph;
        case (piece)
            0:       begin v = '{0, 0, 0, 0};   h = '{0, -1, 1, 2};  end
            1:       begin v = '{0, 0, 1, 1};   h = '{0, 1, 0, 1};   end
            2:       begin v = '{0, 0, 0, -1};  h = '{0, -1, 1, 0};  end
            3:       begin v = '{0, 0, -1, -1}; h = '{0, -1, 0, 1};  end
            4:       begin v = '{0, 0, -1, -1}; h = '{0, 1, 0, -1};  end
            5:       begin v = '{0, 0, 0, -1};  h = '{0, 1, -1, -1}; end
            6:       begin v = '{0, 0, 0, -1};  h = '{0, 1, -1, 1};  end
            default: begin v = '{0, 0, 0, 0};   h = '{0, 0, 0, 0};   end
        endcase
        if (piece == 1) rot = 0;
        for (int k = 0; k < rot; k++) begin
            for (int i = 0; i < 4; i++) begin
                t    = v[i];
                v[i] = h[i];
                h[i] = -t;
            end
        end
        pv = '0;
        ph = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i*W +: W] = W'(v[i]);
            ph[i*W +: W] = W'(h[i] + kick);
        end
        return {ph, pv};
    endfunction

    function automatic model_t cleared(model_t m, bit keepPiece);
        model_t n;
        n        = '0;
        n.ph     = PH_IDLE;
        n.piece  = keepPiece ? m.piece : 7;
        n.halted = keepPiece;
        return n;
    endfunction

    function automatic model_t step(model_t m, bit kickEn);
        model_t n;
        logic [8*W-1:0] s;
        n      = m;
        n.done = 1'b0;
        n.rej  = 1'b0;
        if (rst) begin
            n = cleared(m, 1'b0);
        end else if (!active) begin
            n = cleared(m, 1'b1);
        end else if (load) begin
            n.piece     = int'(pieceType);
            n.rot       = 0;
            n.kickH     = '0;
            s           = refShape(n.piece, 0, 0);
            n.curV      = s[4*W-1:0];
            n.curH      = s[8*W-1:4*W];
            n.candValid = 1'b0;
            n.ph        = PH_IDLE;
            n.att       = 0;
            n.kick      = 0;
            n.waitCnt   = 0;
            n.halted    = 1'b0;
        end else begin
            case (m.ph)
                PH_IDLE: begin
                    if (!m.halted && (rotCw != rotCcw)) begin
                        if (m.piece == 7) begin
                            n.rej = 1'b1;
                        end else begin
                            n.target  = (m.rot + (rotCw ? 1 : 3)) % 4;
                            n.att     = 0;
                            n.kick    = 0;
                            n.waitCnt = 0;
                            n.ph      = PH_PRESENT;
                        end
                    end
                end
                PH_PRESENT: begin
                    s           = refShape(m.piece, m.target, m.kick);
                    n.candV     = s[4*W-1:0];
                    n.candH     = s[8*W-1:4*W];
                    n.candKick  = W'(m.kick);
                    n.candValid = 1'b1;
                    n.waitCnt   = 0;
                    n.ph        = PH_WAIT;
                end
                PH_WAIT: begin
                    if (chkFail) begin
                        n.candValid = 1'b0;
                        n.ph        = PH_RETRY;
                    end else if (chkOk) begin
                        n.ph = PH_COMMIT;
                    end else begin
                        n.waitCnt = m.waitCnt + 1;
                        if (n.waitCnt >= TMO) begin
                            n.candValid = 1'b0;
                            n.ph        = PH_RETRY;
                        end
                    end
                end
                PH_RETRY: begin
                    if (kickEn && m.att < 2) begin
                        n.att     = m.att + 1;
                        n.kick    = (n.att == 1) ? 1 : -1;
                        n.waitCnt = 0;
                        n.ph      = PH_PRESENT;
                    end else begin
                        n.rej = 1'b1;
                        n.ph  = PH_IDLE;
                    end
                end
                default: begin
                    n.rot       = m.target;
                    n.kickH     = m.candKick;
                    n.curV      = m.candV;
                    n.curH      = m.candH;
                    n.done      = 1'b1;
                    n.candValid = 1'b0;
                    n.ph        = PH_IDLE;
                end
            endcase
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("cur_v",      32'(dCurV),      32'(mDef.curV));
        checkOutput("cur_h",      32'(dCurH),      32'(mDef.curH));
        checkOutput("cand_v",     32'(dCandV),     32'(mDef.candV));
        checkOutput("cand_h",     32'(dCandH),     32'(mDef.candH));
        checkOutput("cand_kick",  32'(dCandKick),  32'(mDef.candKick));
        checkOutput("cand_valid", 32'(dCandValid), 32'(mDef.candValid));
        checkOutput("rotation",   32'(dRot),       32'(mDef.rot));
        checkOutput("kick_h",     32'(dKickH),     32'(mDef.kickH));
        checkOutput("busy",       32'(dBusy),      32'(mDef.ph != PH_IDLE));
        checkOutput("rot_done",   32'(dRotDone),   32'(mDef.done));
        checkOutput("rot_rej",    32'(dRotRej),    32'(mDef.rej));
        checkOutput("nk_cur_v",      32'(nCurV),      32'(mNk.curV));
        checkOutput("nk_cur_h",      32'(nCurH),      32'(mNk.curH));
        checkOutput("nk_cand_v",     32'(nCandV),     32'(mNk.candV));
        checkOutput("nk_cand_h",     32'(nCandH),     32'(mNk.candH));
        checkOutput("nk_cand_kick",  32'(nCandKick),  32'(mNk.candKick));
        checkOutput("nk_cand_valid", 32'(nCandValid), 32'(mNk.candValid));
        checkOutput("nk_rotation",   32'(nRot),       32'(mNk.rot));
        checkOutput("nk_kick_h",     32'(nKickH),     32'(mNk.kickH));
        checkOutput("nk_busy",       32'(nBusy),      32'(mNk.ph != PH_IDLE));
        checkOutput("nk_rot_done",   32'(nRotDone),   32'(mNk.done));
        checkOutput("nk_rot_rej",    32'(nRotRej),    32'(mNk.rej));
    endtask

    // Drive one cycle of inputs, advance both models on the edge, compare just after it.
    task automatic applyStimulus(input bit r, input bit a, input bit ld, input logic [2:0] pt,
                                 input bit cw, input bit ccw, input bit ok, input bit fl);
        rst       = r;
        active    = a;
        load      = ld;
        pieceType = pt;
        rotCw     = cw;
        rotCcw    = ccw;
        chkOk     = ok;
        chkFail   = fl;
        @(posedge clk);
        mDef = step(mDef, 1'b1);
        mNk  = step(mNk, 1'b0);
        #1;
        compareAll();
        if (dRotDone) dDoneCnt++;
        if (dRotRej)  dRejCnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic doLoad(input logic [2:0] pt);
        applyStimulus(0, 1, 1, pt, 0, 0, 0, 0);
    endtask

    task automatic waitCandValid(input string tag);
        for (int i = 0; i < 32 && !dCandValid; i++) idle(1);
        checkOutput(tag, 32'(dCandValid), 32'd1);
    endtask

    task automatic settle();
        for (int i = 0; i < 120 && (dBusy || nBusy); i++) idle(1);
        checkOutput("settle", 32'({dBusy, nBusy}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi;
        bit seen;
        int doneBefore;
        int rejBefore;
        bit r, a, ld, cw, ccw, ok, fl;
        logic [2:0] pt;

        mDef = cleared('0, 1'b0);
        mNk  = cleared('0, 1'b0);

        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0, 0);
        checkOutput("rst_outputs", 32'(|{dCurV, dCurH, dCandV, dCandH, dCandValid, dRot, dKickH, dBusy}), 32'd0);

        // J rotates clockwise, accepted in the first WAIT cycle.
        doLoad(3'd5);
        applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
        idle(1);
        checkOutput("j_cand_valid", 32'(dCandValid), 32'd1);
        checkOutput("j_cand_v4", 32'(dCandV[4*W-1 -: W]), 32'h1F);
        checkOutput("j_cand_h4", 32'(dCandH[4*W-1 -: W]), 32'h01);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
        checkOutput("j_done_early", 32'(dRotDone), 32'd0);
        idle(1);
        checkOutput("j_done", 32'(dRotDone), 32'd1);
        checkOutput("j_rotation", 32'(dRot), 32'd1);
        checkOutput("j_cur_v4", 32'(dCurV[4*W-1 -: W]), 32'h1F);
        checkOutput("j_cur_h4", 32'(dCurH[4*W-1 -: W]), 32'h01);
        settle();

        // T counter-clockwise: fail, fail, ok walks the kick sequence 0, +1, -1.
        doLoad(3'd2);
        doneBefore = dDoneCnt;
        rejBefore  = dRejCnt;
        applyStimulus(0, 1, 0, 3'd0, 0, 1, 0, 0);
        waitCandValid("t_valid0");
        checkOutput("t_kick0", 32'(dCandKick), 32'h00);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 0, 1);
        waitCandValid("t_valid1");
        checkOutput("t_kick1", 32'(dCandKick), 32'h01);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 1);
        waitCandValid("t_valid2");
        checkOutput("t_kick2", 32'(dCandKick), 32'h1F);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
        idle(1);
        checkOutput("t_kick_h", 32'(dKickH), 32'h1F);
        checkOutput("t_rotation", 32'(dRot), 32'd3);
        settle();
        checkOutput("t_done_cnt", 32'(dDoneCnt - doneBefore), 32'd1);
        checkOutput("t_rej_cnt", 32'(dRejCnt - rejBefore), 32'd0);

        // No checker response: the non-kicking instance times out once and gives up.
        doLoad(3'd0);
        applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
        hi   = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            idle(1);
            if (nCandValid) hi++;
            if (nRotRej) seen = 1'b1;
        end
        checkOutput("nk_rejected", 32'(seen), 32'd1);
        checkOutput("nk_valid_cycles", 32'(hi), 32'(TMO));
        checkOutput("nk_rot_kept", 32'(nRot), 32'd0);
        checkOutput("nk_cur_h_kept", 32'(nCurH), 32'h107E0);
        checkOutput("nk_cur_v_kept", 32'(nCurV), 32'h0);
        settle();

        // L through a full turn, then O which never changes.
        doLoad(3'd6);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
            waitCandValid("l_valid");
            applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
            idle(1);
            checkOutput("l_rotation", 32'(dRot), 32'((k + 1) % 4));
        end
        checkOutput("l_cur_v0", 32'(dCurV), 32'hF8000);
        checkOutput("l_cur_h0", 32'(dCurH), 32'h0FC20);
        doLoad(3'd1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
            waitCandValid("o_valid");
            applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
            idle(1);
            checkOutput("o_cur_v", 32'(dCurV), 32'h08400);
            checkOutput("o_cur_h", 32'(dCurH), 32'h08020);
        end
        settle();

        // Simultaneous requests are ignored; invalid piece is rejected.
        doLoad(3'd2);
        doneBefore = dDoneCnt;
        rejBefore  = dRejCnt;
        applyStimulus(0, 1, 0, 3'd0, 1, 1, 0, 0);
        checkOutput("both_busy", 32'(dBusy), 32'd0);
        idle(2);
        checkOutput("both_pulses", 32'((dDoneCnt - doneBefore) + (dRejCnt - rejBefore)), 32'd0);
        doLoad(3'd7);
        applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
        checkOutput("p7_rej", 32'(dRotRej), 32'd1);
        checkOutput("p7_offsets", 32'(|{dCurV, dCurH}), 32'd0);

        // Load during WAIT aborts silently; a late ok is ignored.
        doLoad(3'd3);
        applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
        waitCandValid("abort_valid");
        applyStimulus(0, 1, 1, 3'd3, 0, 0, 0, 0);
        checkOutput("abort_cand_valid", 32'(dCandValid), 32'd0);
        checkOutput("abort_busy", 32'(dBusy), 32'd0);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
        idle(1);
        checkOutput("abort_no_done", 32'(dRotDone), 32'd0);
        checkOutput("abort_rotation", 32'(dRot), 32'd0);

        // Dropping active clears outputs and halts until the next load.
        applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0);
        checkOutput("inactive_zero",
                    32'(|{dCurV, dCurH, dCandV, dCandH, dCandKick, dCandValid, dRot, dKickH, dBusy, dRotDone, dRotRej}),
                    32'd0);
        applyStimulus(0, 1, 0, 3'd0, 1, 0, 0, 0);
        checkOutput("halted_busy", 32'(dBusy), 32'd0);

        // Reset in the middle of a handshake.
        doLoad(3'd4);
        applyStimulus(0, 1, 0, 3'd0, 0, 1, 0, 0);
        waitCandValid("rst_mid_valid");
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0, 0);
        checkOutput("rst_mid_cand_valid", 32'(dCandValid), 32'd0);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1, 0);
        checkOutput("rst_mid_no_done", 32'(dRotDone), 32'd0);

        // Randomised traffic, alternating between chatty and quiet checker periods.
        for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 299) == 0);
            a   = ($urandom_range(0, 149) != 0);
            ld  = ($urandom_range(0, 29) == 0);
            pt  = 3'($urandom_range(0, 7));
            cw  = ($urandom_range(0, 3) == 0);
            ccw = ($urandom_range(0, 4) == 0);
            if (((c / 500) % 2) == 1) begin
                ok = ($urandom_range(0, 39) == 0);
                fl = ($urandom_range(0, 49) == 0);
            end else begin
                ok = ($urandom_range(0, 2) == 0);
                fl = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(r, a, ld, pt, cw, ccw, ok, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
